// File: rtl/display_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed seven-segment display: refresh timebase,
// anti-ghosting blank guard, tear-free shadowed hex value with leading-zero blanking.
module display_scan_ctrl #(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic [3:0]  digit_en,
    input  logic        lzb,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        pending,
    output logic        frame_done
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } phase_e;

    // With no blank guard every slot starts straight in DRIVE.
    localparam phase_e SLOT_START = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    d_q, d_d;
    phase_e        state_q, state_d;
    logic [15:0]   staging_val_q, staging_val_d;
    logic [3:0]    staging_dp_q, staging_dp_d;
    logic [15:0]   shadow_val_q, shadow_val_d;
    logic [3:0]    shadow_dp_q, shadow_dp_d;
    logic          pending_q, pending_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_done_q, frame_done_d;
    logic          wrap_s, boundary_s;
    logic [3:0]    nib_s;
    logic [3:0]    zb_s;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] r;
        case (n)
            4'h0:    r = 7'b1000000;
            4'h1:    r = 7'b1111001;
            4'h2:    r = 7'b0100100;
            4'h3:    r = 7'b0110000;
            4'h4:    r = 7'b0011001;
            4'h5:    r = 7'b0010010;
            4'h6:    r = 7'b0000010;
            4'h7:    r = 7'b1111000;
            4'h8:    r = 7'b0000000;
            4'h9:    r = 7'b0010000;
            4'hA:    r = 7'b0001000;
            4'hB:    r = 7'b0000011;
            4'hC:    r = 7'b1000110;
            4'hD:    r = 7'b0100001;
            4'hE:    r = 7'b0000110;
            4'hF:    r = 7'b0001110;
            default: r = 7'b1111111;
        endcase
        return r;
    endfunction

    // Timebase, phase FSM, staging/shadow handshake and frame pulse next-state.
    always_comb begin
        wrap_s        = (cnt_q == CNT_LAST);
        boundary_s    = wrap_s && (d_q == 2'd3);
        cnt_d         = cnt_q;
        d_d           = d_q;
        state_d       = state_q;
        staging_val_d = staging_val_q;
        staging_dp_d  = staging_dp_q;
        shadow_val_d  = shadow_val_q;
        shadow_dp_d   = shadow_dp_q;
        pending_d     = pending_q;
        frame_done_d  = boundary_s;

        if (wrap_s) begin
            cnt_d   = '0;
            d_d     = d_q + 2'd1;
            state_d = SLOT_START;
        end else begin
            cnt_d = cnt_q + CW'(1);
            if ((state_q == ST_BLANK) && (cnt_q == BLANK_LAST)) begin
                state_d = ST_DRIVE;
            end else begin
                state_d = state_q;
            end
        end

        // Commit uses pre-edge staging; a load on the same edge stays pending.
        if (boundary_s && pending_q) begin
            shadow_val_d = staging_val_q;
            shadow_dp_d  = staging_dp_q;
            pending_d    = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        if (load) begin
            staging_val_d = value;
            staging_dp_d  = dp_in;
            pending_d     = 1'b1;
        end else begin
            staging_val_d = staging_val_q;
        end
    end

    // Display outputs computed from next-state values so the registered pins line up with cnt/d.
    always_comb begin
        nib_s = shadow_val_d[{d_d, 2'b00} +: 4];
        zb_s[3] = (shadow_val_d[15:12] == 4'h0);
        zb_s[2] = zb_s[3] && (shadow_val_d[11:8] == 4'h0);
        zb_s[1] = zb_s[2] && (shadow_val_d[7:4] == 4'h0);
        zb_s[0] = 1'b0;
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;

        if ((state_d == ST_BLANK) || !digit_en[d_d]) begin
            an_d  = 4'b1111;
            seg_d = 7'b1111111;
            dp_d  = 1'b1;
        end else if (lzb && zb_s[d_d]) begin
            seg_d = 7'b1111111;
            if (shadow_dp_d[d_d]) begin
                an_d = ~(4'b0001 << d_d);
                dp_d = 1'b0;
            end else begin
                an_d = 4'b1111;
                dp_d = 1'b1;
            end
        end else begin
            an_d  = ~(4'b0001 << d_d);
            seg_d = hex7(nib_s);
            dp_d  = ~shadow_dp_d[d_d];
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            d_q           <= 2'd0;
            state_q       <= SLOT_START;
            staging_val_q <= 16'h0000;
            staging_dp_q  <= 4'h0;
            shadow_val_q  <= 16'h0000;
            shadow_dp_q   <= 4'h0;
            pending_q     <= 1'b0;
            an_q          <= 4'b1111;
            seg_q         <= 7'b1111111;
            dp_q          <= 1'b1;
            frame_done_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            d_q           <= d_d;
            state_q       <= state_d;
            staging_val_q <= staging_val_d;
            staging_dp_q  <= staging_dp_d;
            shadow_val_q  <= shadow_val_d;
            shadow_dp_q   <= shadow_dp_d;
            pending_q     <= pending_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with CLK_DIV=8, BLANK_CYCLES=2 (32-cycle frame).
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        load = 1'b0;
    logic [3:0]  digit_en = 4'hF;
    logic        lzb = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        pending;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int t       = 0;

    display_scan_ctrl #(.CLK_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
        .digit_en(digit_en), .lzb(lzb), .an(an), .seg(seg), .dp(dp),
        .pending(pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp_in;
        logic [3:0]  den;
        logic        lzb;
        logic [15:0] exp_an;   // {digit3, digit2, digit1, digit0}
        logic [27:0] exp_seg;
        logic [3:0]  exp_dp;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (t=%0d): got %0h expected %0h", name, t, act, exp);
        end
    endtask

    // Advance to frame position p (cycle index within the 32-cycle frame).
    task automatic goto_p(input int p);
        int k;
        k = 0;
        while ((t % 32) != p && k < 64) begin
            tick();
            k++;
        end
        if ((t % 32) != p) chk("goto_timeout", 32'(t % 32), 32'(p));
    endtask

    initial begin
        vecs[0] = '{16'hA5F0, 4'b0100, 4'hF, 1'b0, 16'h7BDE, {7'h08, 7'h12, 7'h0E, 7'h40}, 4'b1011};
        vecs[1] = '{16'h0007, 4'b0100, 4'hF, 1'b1, 16'hFBFE, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'b1011};
        vecs[2] = '{16'h1234, 4'b0000, 4'b0101, 1'b0, 16'hFBFE, {7'h7F, 7'h24, 7'h7F, 7'h19}, 4'b1111};
        vecs[3] = '{16'hCB98, 4'b1001, 4'hF, 1'b1, 16'h7BDE, {7'h46, 7'h03, 7'h10, 7'h00}, 4'b0110};
        vecs[4] = '{16'hFED6, 4'b0000, 4'hF, 1'b0, 16'h7BDE, {7'h0E, 7'h06, 7'h21, 7'h02}, 4'b1111};
        vecs[5] = '{16'h0301, 4'b0000, 4'hF, 1'b1, 16'hFBDE, {7'h7F, 7'h30, 7'h40, 7'h79}, 4'b1111};
        vecs[6] = '{16'h0000, 4'b0000, 4'hF, 1'b1, 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};

        // Reset and idle scan over two frames.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        t = 0;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        for (int i = 1; i <= 64; i++) begin
            int p;
            int dd;
            int c;
            logic [3:0] ea;
            tick();
            p  = t % 32;
            dd = p / 8;
            c  = p % 8;
            ea = (c < 2) ? 4'hF : ~(4'b0001 << dd);
            chk("scan_an", 32'(an), 32'(ea));
            chk("scan_seg", 32'(seg), (c < 2) ? 32'h7F : 32'h40);
            chk("scan_frame_done", 32'(frame_done), (p == 0) ? 32'h1 : 32'h0);
        end

        // Table-driven display vectors.
        for (int v = 0; v < 7; v++) begin
            digit_en = vecs[v].den;
            lzb      = vecs[v].lzb;
            value    = vecs[v].value;
            dp_in    = vecs[v].dp_in;
            goto_p(8);
            load = 1'b1;
            tick();
            load = 1'b0;
            chk("vec_pending_set", 32'(pending), 32'h1);
            goto_p(0);
            for (int k = 0; k < 4; k++) begin
                goto_p(8 * k + 4);
                if (k == 0) chk("vec_pending_clr", 32'(pending), 32'h0);
                chk($sformatf("vec%0d_an_d%0d", v, k), 32'(an), 32'(vecs[v].exp_an[4*k +: 4]));
                chk($sformatf("vec%0d_seg_d%0d", v, k), 32'(seg), 32'(vecs[v].exp_seg[7*k +: 7]));
                chk($sformatf("vec%0d_dp_d%0d", v, k), 32'(dp), 32'(vecs[v].exp_dp[k]));
            end
        end

        // Disabled digits stay dark for the whole slot; slot timing unchanged.
        digit_en = 4'b0101;
        lzb      = 1'b0;
        goto_p(7);
        for (int k = 0; k < 11; k++) begin
            tick();
            chk("den_an", 32'(an), (k < 10) ? 32'hF : 32'hB);
        end

        // Two loads in one frame: last one wins.
        digit_en = 4'hF;
        dp_in    = 4'h0;
        goto_p(5);
        value = 16'h1234;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        goto_p(10);
        value = 16'h5678;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        goto_p(0);
        goto_p(4);
        chk("two_loads_d0", 32'(seg), 32'h00);
        goto_p(28);
        chk("two_loads_d3", 32'(seg), 32'h12);

        // Load on the boundary cycle commits one frame later.
        goto_p(20);
        value = 16'h1111;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        goto_p(31);
        value = 16'h2222;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        chk("bnd_pending_held", 32'(pending), 32'h1);
        goto_p(4);
        chk("bnd_first_frame", 32'(seg), 32'h79);
        goto_p(0);
        chk("bnd_pending_clr", 32'(pending), 32'h0);
        goto_p(4);
        chk("bnd_second_frame", 32'(seg), 32'h24);

        // Reset mid-frame with a staged value discards it.
        goto_p(17);
        value = 16'h3333;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        chk("mid_rst_pending_before", 32'(pending), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        t = 0;
        chk("mid_rst_an", 32'(an), 32'hF);
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        chk("mid_rst_pending", 32'(pending), 32'h0);
        chk("mid_rst_frame_done", 32'(frame_done), 32'h0);
        goto_p(2);
        chk("mid_rst_d0", 32'(an), 32'hE);
        goto_p(0);
        chk("mid_rst_fd_next", 32'(frame_done), 32'h1);
        goto_p(4);
        chk("mid_rst_no_stale", 32'(seg), 32'h40);
        chk("mid_rst_pending_after", 32'(pending), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
